// File: rtl/tx_fifo_serializer_if.sv
// tx_fifo_serializer_if
//   Bundles the bus-side push path, the FIFO status flags and the
//   valid/ready byte stream toward the peripheral transmitter.
//   master: the environment (bus writer plus peripheral).
//   slave : the tx_fifo_serializer block itself.
interface tx_fifo_serializer_if #(
  parameter int AW = 8
);
  // Bus-side push path
  logic          write_fifo_en;
  logic [31:0]   in_fifo;

  // FIFO status
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          busy;

  // Byte stream toward the peripheral transmitter
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          tx_ready;

  // Sticky overflow flag and its clear
  logic          ovf;
  logic          ovf_clr;

  modport master (
    output write_fifo_en,
    output in_fifo,
    output tx_ready,
    output ovf_clr,
    input  full,
    input  empty,
    input  level,
    input  busy,
    input  tx_byte,
    input  tx_valid,
    input  ovf
  );

  modport slave (
    input  write_fifo_en,
    input  in_fifo,
    input  tx_ready,
    input  ovf_clr,
    output full,
    output empty,
    output level,
    output busy,
    output tx_byte,
    output tx_valid,
    output ovf
  );
endinterface

// File: rtl/tx_fifo_serializer.sv
// tx_fifo_serializer
//   Transmit-side word FIFO (2**AW deep) followed by a word-to-byte
//   serializer. Words pushed from the bus are popped one at a time into a
//   32-bit shift register and offered LSB-first as four bytes on a
//   valid/ready stream. Back-to-back words stream without a bubble.
//   Optional feature: define TX_FIFO_OVF_EN to get a sticky overflow flag
//   that sets on a push attempt while full and clears on ovf_clr.
//   Without the macro ovf is constant 0 and ovf_clr is ignored.
//   Reset is asynchronous, active-low, released synchronously upstream.
module tx_fifo_serializer #(
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tx_fifo_serializer_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic [AW:0]  level;
  logic         full;
  logic         empty;

  logic [31:0]  mem [DEPTH];
  logic [31:0]  shift;
  logic [1:0]   byte_cnt;

  logic         push;
  logic         load;
  logic         advance;
  logic         valid;

  assign level = wp - rp;
  assign full  = (level == FULL_LVL);
  assign empty = (wp == rp);

  // A push while full is dropped even if a pop frees a slot this cycle.
  assign push  = bus.write_fifo_en && !full;

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.busy     = (state == SEND);
  assign bus.tx_valid = valid;
  assign bus.tx_byte  = shift[7:0];

  // Serializer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Serializer next state: load a word when one is queued, step through its
  // four bytes on accepted transfers, and chain straight into the next word.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        valid = 1'b1;
        if (bus.tx_ready) begin
          if (byte_cnt != 2'd3) begin
            advance = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
    end else if (push) begin
      wp <= wp + 1'b1;
    end
  end

  // Storage array; deliberately not reset, only the pointers define content.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp[AW-1:0]] <= bus.in_fifo;
    end
  end

  // Pop into the shift register on load; otherwise shift out one byte per
  // accepted transfer. tx_byte holds while the peripheral stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp       <= '0;
      shift    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shift    <= mem[rp[AW-1:0]];
      rp       <= rp + 1'b1;
      byte_cnt <= 2'd0;
    end else if (advance) begin
      shift    <= {8'h00, shift[31:8]};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

`ifdef TX_FIFO_OVF_EN
  logic ovf;

  assign bus.ovf = ovf;

  // Sticky overflow: a dropped push sets it, ovf_clr clears it, set wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (bus.write_fifo_en && full) begin
      ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`else
  logic ovf_clr_unused;

  assign bus.ovf        = 1'b0;
  assign ovf_clr_unused = bus.ovf_clr;
`endif

endmodule

// File: tb/tb_tx_fifo_serializer.sv
// tb_tx_fifo_serializer
//   Randomized and directed stimulus against a byte-queue reference model:
//   every accepted word appends its four bytes LSB-first to a queue, and
//   every valid&ready transfer must pop the matching byte. Stalls must hold
//   tx_byte stable. Directed sequences cover latency, back-to-back words,
//   fill to full with a dropped push, pointer wrap and reset mid-word.
`timescale 1ns/1ps
module tb_tx_fifo_serializer;

  localparam int AW = 8;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic reset = 1'b0;

  tx_fifo_serializer_if #(.AW(AW)) bus ();

  tx_fifo_serializer #(.AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] exp_q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte  = 8'h00;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  function automatic logic [8:0] next_exp();
    if (exp_q.size() > 0) return {1'b0, exp_q.pop_front()};
    return 9'h100;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_left"}, exp_q.size(), 0);
  endtask

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.tx_valid, 1);
        chk("hold_byte", bus.tx_byte, prev_byte);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chk("stream_byte", {1'b0, bus.tx_byte}, next_exp());
      end
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_byte  <= bus.tx_byte;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] w2;
    int sent;
    int cyc;

    bus.write_fifo_en = 1'b0;
    bus.in_fifo       = '0;
    bus.tx_ready      = 1'b0;
    bus.ovf_clr       = 1'b0;
    reset             = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_full", bus.full, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_level", bus.level, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.tx_valid, 0);
    chk("rst_byte", bus.tx_byte, 0);
    chk("rst_ovf", bus.ovf, 0);
    reset = 1'b1;
    tick();

    // Test 1: single word, latency and LSB-first order
    w = 32'h44332211;
    bus.tx_ready      = 1'b1;
    bus.write_fifo_en = 1'b1;
    bus.in_fifo       = w;
    push_model(w);
    tick();
    bus.write_fifo_en = 1'b0;
    chk("t1_n1_valid", bus.tx_valid, 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      chk("t1_valid", bus.tx_valid, 1);
      chk("t1_byte", bus.tx_byte, w[8*b +: 8]);
      tick();
    end
    chk("t1_end_valid", bus.tx_valid, 0);
    chk("t1_end_busy", bus.busy, 0);
    chk("t1_end_empty", bus.empty, 1);

    // Test 2: stall holds byte0
    w = 32'hA1B2C3D4;
    bus.tx_ready      = 1'b0;
    bus.write_fifo_en = 1'b1;
    bus.in_fifo       = w;
    push_model(w);
    tick();
    bus.write_fifo_en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", bus.tx_valid, 1);
      chk("t2_stall_byte", bus.tx_byte, 8'hD4);
      tick();
    end
    bus.tx_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      chk("t2_byte", bus.tx_byte, w[8*b +: 8]);
      tick();
    end
    chk("t2_end_valid", bus.tx_valid, 0);

    // Test 3: back-to-back words, no bubble
    w  = 32'h03020100;
    w2 = 32'h07060504;
    bus.tx_ready      = 1'b1;
    bus.write_fifo_en = 1'b1;
    bus.in_fifo       = w;
    push_model(w);
    tick();
    bus.in_fifo = w2;
    push_model(w2);
    tick();
    bus.write_fifo_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t3_valid", bus.tx_valid, 1);
      chk("t3_byte", bus.tx_byte, i);
      tick();
    end
    chk("t3_end_valid", bus.tx_valid, 0);

    // Test 4: fill to full with the peripheral stalled
    bus.tx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bus.write_fifo_en = 1'b1;
      bus.in_fifo       = 32'h1000_0000 + 32'(i);
      if (i < DEPTH + 1) push_model(32'h1000_0000 + 32'(i));
      tick();
      if (i == DEPTH) begin
        chk("t4_level_257", bus.level, DEPTH);
        chk("t4_full_257", bus.full, 1);
        chk("t4_ovf_257", bus.ovf, 0);
        chk("t4_busy", bus.busy, 1);
      end
    end
    bus.write_fifo_en = 1'b0;
    chk("t4_level_258", bus.level, DEPTH);
    chk("t4_full_258", bus.full, 1);
    chk("t4_byte0", bus.tx_byte, 8'h00);
`ifdef TX_FIFO_OVF_EN
    chk("t4_ovf_set", bus.ovf, 1);
`else
    chk("t4_ovf_tied", bus.ovf, 0);
`endif
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", bus.ovf, 0);
    bus.tx_ready = 1'b1;
    drain("t4", 1200);
    tick();
    chk("t4_end_empty", bus.empty, 1);
    chk("t4_end_valid", bus.tx_valid, 0);

    // Test 5: random streaming of 600 incrementing words
    sent = 0;
    cyc  = 0;
    while (sent < 600 && cyc < 20000) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() < 800 && $urandom_range(0, 3) != 0) begin
        bus.write_fifo_en = 1'b1;
        bus.in_fifo       = 32'(sent);
        push_model(32'(sent));
        sent++;
      end else begin
        bus.write_fifo_en = 1'b0;
      end
      tick();
      cyc++;
      chk("t5_full", bus.full, 0);
    end
    bus.write_fifo_en = 1'b0;
    chk("t5_sent", sent, 600);
    bus.tx_ready = 1'b1;
    drain("t5", 4000);
    tick();
    chk("t5_end_level", bus.level, 0);
    chk("t5_end_empty", bus.empty, 1);

    // Test 6: reset after byte1 of a word with another word queued
    w  = 32'h5A4B3C2D;
    w2 = 32'h99887766;
    bus.tx_ready      = 1'b1;
    bus.write_fifo_en = 1'b1;
    bus.in_fifo       = w;
    push_model(w);
    tick();
    bus.in_fifo = w2;
    push_model(w2);
    tick();
    bus.write_fifo_en = 1'b0;
    tick();
    tick();
    chk("t6_pre_byte2", bus.tx_byte, 8'h4B);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", bus.tx_valid, 0);
    chk("t6_rst_level", bus.level, 0);
    chk("t6_rst_empty", bus.empty, 1);
    chk("t6_rst_busy", bus.busy, 0);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_quiet_valid", bus.tx_valid, 0);
    end
    w = 32'hCAFEF00D;
    bus.write_fifo_en = 1'b1;
    bus.in_fifo       = w;
    push_model(w);
    tick();
    bus.write_fifo_en = 1'b0;
    drain("t6", 20);
    tick();
    chk("t6_end_empty", bus.empty, 1);
    chk("t6_end_valid", bus.tx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
